// File: rtl/seven_seg_scan.sv
// Time-multiplexed BCD driver for a DIGITS-wide common-segment seven-segment display.
// Define SEVEN_SEG_SCAN_HEX_EN to render nibbles 10..15 as A,b,C,d,E,F instead of blank segments.
module seven_seg_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   dpr_q, dpr_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                wrap_q, wrap_d;
    logic                frame_q, frame_d;

    logic       tc;
    logic       idx_last;
    logic [3:0] nib;
    logic       dp_bit;
    logic       zero_above;
    logic       blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
`ifdef SEVEN_SEG_SCAN_HEX_EN
            4'd10:   s = 7'b1110111;
            4'd11:   s = 7'b0011111;
            4'd12:   s = 7'b1001110;
            4'd13:   s = 7'b0111101;
            4'd14:   s = 7'b1001111;
            default: s = 7'b1000111;
`else
            default: s = 7'b0000000;
`endif
        endcase
        return s;
    endfunction

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        tc         = (presc_q == PS_LAST);
        idx_last   = (idx_q == IDX_LAST);
        presc_d    = tc ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        if (tc) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        // The wrap is seen here one cycle before digit_en returns to bit 0, so delay it once.
        wrap_d     = tc && idx_last;
        frame_d    = wrap_q;
        disp_d     = load ? value : disp_q;
        dpr_d      = load ? dp_in : dpr_q;

        nib        = 4'd0;
        dp_bit     = 1'b0;
        zero_above = 1'b1;
        blank      = 1'b0;
        en_d       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                nib    = disp_q[4*i +: 4];
                dp_bit = dpr_q[i];
                blank  = blank_lz && (i != 0) && zero_above;
            end
            en_d[i] = (idx_q == IDX_W'(i));
        end
        seg_d = blank ? 7'd0 : decode(nib);
        dp_d  = dp_bit && !blank;
    end

    // NOTE: synchronous reset; all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            dpr_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            en_q    <= '0;
            wrap_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            dpr_q   <= dpr_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
            frame_q <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_en   = en_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized self-checking bench: a 4-digit/prescale-3 instance and a 1-digit/prescale-1 instance
// share stimulus and are compared every cycle against a time-indexed reference model.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  en_a;
    logic        en_b;
    logic        fd_a, fd_b;

    int n_checks = 0;
    int n_errors = 0;

    seven_seg_scan #(.DIGITS(4), .PRESCALE(3)) u_dut_a (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
        .seg(seg_a), .dp(dp_a), .digit_en(en_a), .frame_done(fd_a)
    );

    seven_seg_scan #(.DIGITS(1), .PRESCALE(1)) u_dut_b (
        .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0]), .load(load), .blank_lz(blank_lz),
        .seg(seg_b), .dp(dp_b), .digit_en(en_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

`ifdef SEVEN_SEG_SCAN_HEX_EN
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`else
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
`endif

    // Model state per instance: edges since reset release, latched word, latched dp bits.
    int          mt [2];
    logic [15:0] md [2];
    logic [3:0]  mp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs after edge t (t>=1 since release) show digit ((t-1)/P) mod D using data latched before this edge.
    task automatic model_step(input int inst, input int nd, input int np, input logic r, input logic ld,
                              input logic [15:0] v, input logic [3:0] d, input logic b,
                              output logic [6:0] e_seg, output logic e_dp, output logic [3:0] e_en,
                              output logic e_fd);
        int          dig;
        logic [15:0] sh;
        logic        blank;
        e_seg = '0; e_dp = 1'b0; e_en = '0; e_fd = 1'b0;
        if (r) begin
            mt[inst] = 0;
            md[inst] = '0;
            mp[inst] = '0;
        end else begin
            mt[inst]++;
            dig   = ((mt[inst] - 1) / np) % nd;
            sh    = md[inst] >> (4 * dig);
            blank = b && (dig > 0) && (sh == 16'd0);
            e_en  = 4'b0001 << dig;
            e_seg = blank ? 7'd0 : SEG_TAB[sh[3:0]];
            e_dp  = blank ? 1'b0 : mp[inst][dig];
            e_fd  = (mt[inst] > 1) && (((mt[inst] - 1) % (np * nd)) == 0);
            if (ld) begin
                md[inst] = v;
                mp[inst] = d;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d, input logic b);
        logic [6:0] sa, sb;
        logic       pa, pb, fa, fb;
        logic [3:0] ea, eb;
        @(negedge clk);
        rst = r; load = ld; value = v; dp_in = d; blank_lz = b;
        model_step(0, 4, 3, r, ld, v, d, b, sa, pa, ea, fa);
        model_step(1, 1, 1, r, ld, v & 16'h000F, d & 4'b0001, b, sb, pb, eb, fb);
        @(posedge clk);
        #1;
        check("a_seg", 32'(seg_a), 32'(sa));
        check("a_dp", 32'(dp_a), 32'(pa));
        check("a_en", 32'(en_a), 32'(ea));
        check("a_frame", 32'(fd_a), 32'(fa));
        check("b_seg", 32'(seg_b), 32'(sb));
        check("b_dp", 32'(dp_b), 32'(pb));
        check("b_en", 32'(en_b), 32'(eb));
        check("b_frame", 32'(fd_b), 32'(fb));
    endtask

    task automatic run(input int n, input logic b);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, value, dp_in, b);
    endtask

    initial begin
        logic [15:0] rv;
        logic        rb;

        cycle(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
        check("rst_en", 32'(en_a), 32'd0);

        // Scan order with 1234; digit 0 shows '4' once the loaded word reaches the output.
        cycle(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h1234, 4'b0000, 1'b0);
        check("plan_d0_seg", 32'(seg_a), 32'(7'b0110011));
        run(17, 1'b0);
        // Mid-frame reset while digit 2 is active.
        cycle(1'b1, 1'b0, 16'h1234, 4'b0000, 1'b0);
        check("midrst_en", 32'(en_a), 32'd0);
        run(14, 1'b0);

        cycle(1'b0, 1'b1, 16'h0070, 4'b0000, 1'b1);
        run(13, 1'b1);
        run(13, 1'b0);
        cycle(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
        run(13, 1'b1);
        cycle(1'b0, 1'b1, 16'h0123, 4'b0100, 1'b1);
        run(13, 1'b1);
        cycle(1'b0, 1'b1, 16'h0003, 4'b0100, 1'b1);
        run(13, 1'b1);
        cycle(1'b0, 1'b1, 16'h000A, 4'b0001, 1'b0);
        run(13, 1'b0);

        // Load timing: realign to digit 0, then change nibble 0 from 5 to 8 mid-digit.
        cycle(1'b1, 1'b0, 16'h0005, 4'b0000, 1'b0);
        cycle(1'b0, 1'b1, 16'h0005, 4'b0000, 1'b0);
        run(12, 1'b0);
        check("lt_before", 32'(seg_a), 32'(7'b1011011));
        cycle(1'b0, 1'b1, 16'h0008, 4'b0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0008, 4'b0000, 1'b0);
        check("lt_after", 32'(seg_a), 32'(7'b1111111));

        rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                rv[4*k +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
            if ($urandom_range(15) == 0) rb = ~rb;
            cycle(($urandom_range(199) == 0), ($urandom_range(7) == 0), rv, 4'($urandom_range(15)), rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
